npc_lsu: RTL and testbench

- Multi-cycle load/store unit for the NPC core.
- Sits between the execute stage (address already computed by the ALU adder) and the data-memory port.
- Replaces the combinational, single-cycle memory read with a valid/ready request/response handshake.
- Adds byte/half/word loads and stores with sign or zero extension, write-mask generation, misalignment detection and a memory-response timeout.

---
 rtl/npc_lsu.sv | 216 +++++++++++++++++++++
 tb/tb_npc_lsu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_lsu.sv
// npc_lsu: multi-cycle load/store unit between execute and the data-memory port.
// Request/response handshakes on both sides, sub-word access, misalign and timeout errors.
module npc_lsu #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_wen,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wmask,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int CW   = $clog2(MAX_WAIT + 1);

   // One-hot so every handshake output is a direct flop bit
   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_REQ  = 4'b0010,
      S_WAIT = 4'b0100,
      S_RESP = 4'b1000
   } state_e;

   state_e            state_q, state_d;
   logic              wen_q, wen_d;
   logic [2:0]        f3_q, f3_d;
   logic [OFFW-1:0]   off_q, off_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [NB-1:0]     wmask_q, wmask_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [OFFW-1:0]   req_off;
   logic [NB-1:0]     base_mask;
   logic              illegal;
   logic              misalign;
   logic [XLEN-1:0]   lane;
   logic [XLEN-1:0]   ext;
   logic [XLEN-1:0]   load_val;
   logic [CW-1:0]     cnt_inc;

   assign req_off = req_addr[OFFW-1:0];
   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      base_mask = '0;
      misalign  = 1'b0;
      unique case (req_funct3[1:0])
         2'd0: begin
            base_mask = NB'(1);
            misalign  = 1'b0;
         end
         2'd1: begin
            base_mask = NB'(3);
            misalign  = req_addr[0];
         end
         2'd2: begin
            base_mask = NB'(15);
            misalign  = |req_addr[1:0];
         end
         default: begin
            base_mask = '1;
            misalign  = |req_addr[2:0];
         end
      endcase
   end

   // Stores have no unsigned forms; d/wu exist only on RV64
   always_comb begin
      illegal = 1'b0;
      unique case (1'b1)
         (req_funct3 == 3'b111):            illegal = 1'b1;
         (req_wen && req_funct3[2]):        illegal = 1'b1;
         ((XLEN == 32) &&
          ((req_funct3 == 3'b011) ||
           (req_funct3 == 3'b110))):        illegal = 1'b1;
         default:                           illegal = 1'b0;
      endcase
   end

   always_comb begin
      lane = mem_rdata >> {off_q, 3'b000};
      ext  = lane;
      case (f3_q)
         3'b000:  ext = XLEN'($signed(lane[7:0]));
         3'b001:  ext = XLEN'($signed(lane[15:0]));
         3'b010:  ext = XLEN'($signed(lane[31:0]));
         3'b100:  ext = XLEN'(lane[7:0]);
         3'b101:  ext = XLEN'(lane[15:0]);
         3'b110:  ext = XLEN'(lane[31:0]);
         default: ext = lane;
      endcase
      load_val = wen_q ? '0 : ext;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         wen_q   <= 1'b0;
         f3_q    <= '0;
         off_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wen_d   = wen_q;
      f3_d    = f3_q;
      off_d   = off_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               wen_d   = req_wen;
               f3_d    = req_funct3;
               off_d   = req_off;
               addr_d  = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
               wdata_d = req_wen ? (req_wdata << {req_off, 3'b000}) : '0;
               wmask_d = req_wen ? (base_mask << req_off) : '0;
               rdata_d = '0;
               err_d   = 1'b0;
               cnt_d   = '0;
               if (illegal || misalign) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (mem_ready) begin
               cnt_d = '0;
               if (mem_rvalid) begin
                  rdata_d = load_val;
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               rdata_d = load_val;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CW'(MAX_WAIT)) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == S_IDLE);
      resp_valid = (state_q == S_RESP);
      mem_valid  = (state_q == S_REQ);
      mem_wen    = (state_q == S_REQ) && wen_q;
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      mem_wmask  = wmask_q;
      resp_rdata = rdata_q;
      resp_err   = err_q;
   end

endmodule

// File: tb/tb_npc_lsu.sv
// tb_npc_lsu: scoreboard bench for npc_lsu (XLEN=32, MAX_WAIT=4).
// Expected responses are queued at issue and popped on each response handshake.
module tb_npc_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   npc_lsu #(.XLEN(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_wen(req_wen), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic push, input logic [31:0] e_rd,
                        input logic e_err);
      exp_t e;
      chk("req_ready", req_ready, 1);
      if (push) begin
         e.rdata = e_rd;
         e.err   = e_err;
         sb.push_back(e);
      end
      req_valid  = 1'b1;
      req_wen    = wen;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(negedge clk);
      req_valid  = 1'b0;
   endtask

   task automatic mem_txn(input logic [31:0] e_addr, input logic e_wen,
                          input logic [3:0] e_mask, input logic [31:0] e_wd,
                          input int gap, input logic same,
                          input logic [31:0] rd);
      logic found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mem_valid) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("mv_seen", found, 1);
      @(negedge clk);
      chk("mv_hold", mem_valid, 1);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wen", mem_wen, e_wen);
      chk("mem_wmask", mem_wmask, e_mask);
      if (e_wen) chk("mem_wdata", mem_wdata, e_wd);
      mem_ready = 1'b1;
      if (same) begin
         mem_rvalid = 1'b1;
         mem_rdata  = rd;
      end
      @(negedge clk);
      mem_ready = 1'b0;
      if (!same) begin
         chk("mv_drop", mem_valid, 0);
         repeat (gap) @(negedge clk);
         mem_rvalid = 1'b1;
         mem_rdata  = rd;
         @(negedge clk);
      end
      mem_rvalid = 1'b0;
   endtask

   task automatic get_resp(input int hold);
      logic found = 1'b0;
      exp_t e;
      for (int i = 0; i < 20; i++) begin
         if (resp_valid) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("resp_seen", found, 1);
      if (!found) return;
      chk("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk("resp_rdata", resp_rdata, e.rdata);
      chk("resp_err", resp_err, e.err);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", resp_valid, 1);
         chk("hold_rdata", resp_rdata, e.rdata);
         chk("hold_err", resp_err, e.err);
         chk("hold_rready", req_ready, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("resp_drop", resp_valid, 0);
      chk("idle_ready", req_ready, 1);
   endtask

   initial begin
      int n;
      rst = 1'b0;
      req_valid = 1'b0; req_wen = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      rst = 1'b1;
      @(negedge clk);

      // lb with sign extension, data two cycles after mem_ready
      issue(0, 3'b000, 32'h8000_0003, 0, 1, 32'hFFFF_FF80, 0);
      mem_txn(32'h8000_0000, 0, 4'b0000, 0, 1, 0, 32'h80FF_12AB);
      get_resp(0);

      issue(0, 3'b101, 32'h8000_0002, 0, 1, 32'h0000_9ABC, 0);
      mem_txn(32'h8000_0000, 0, 4'b0000, 0, 0, 0, 32'h9ABC_1234);
      get_resp(0);

      issue(0, 3'b001, 32'h8000_0002, 0, 1, 32'hFFFF_9ABC, 0);
      mem_txn(32'h8000_0000, 0, 4'b0000, 0, 2, 0, 32'h9ABC_1234);
      get_resp(0);

      issue(1, 3'b001, 32'h8000_0002, 32'h1234_5678, 1, 0, 0);
      mem_txn(32'h8000_0000, 1, 4'b1100, 32'h5678_0000, 0, 0, 32'hFFFF_FFFF);
      get_resp(0);

      // sb acknowledged in the same cycle as mem_ready
      issue(1, 3'b000, 32'h8000_0101, 32'h1234_56AB, 1, 0, 0);
      mem_txn(32'h8000_0100, 1, 4'b0010, 32'h3456_AB00, 0, 1, 32'h5555_5555);
      get_resp(0);

      issue(0, 3'b100, 32'h8000_0001, 0, 1, 32'h0000_0083, 0);
      mem_txn(32'h8000_0000, 0, 4'b0000, 0, 0, 1, 32'h1122_8344);
      get_resp(0);

      issue(0, 3'b010, 32'h8000_0008, 0, 1, 32'hCAFE_F00D, 0);
      mem_txn(32'h8000_0008, 0, 4'b0000, 0, 3, 0, 32'hCAFE_F00D);
      get_resp(0);

      // misaligned lw responds next cycle without touching memory
      issue(0, 3'b010, 32'h8000_0001, 0, 1, 0, 1);
      chk("mis_mem_valid", mem_valid, 0);
      chk("mis_resp_valid", resp_valid, 1);
      get_resp(0);

      issue(0, 3'b011, 32'h8000_0000, 0, 1, 0, 1);
      chk("ill_mem_valid", mem_valid, 0);
      chk("ill_resp_valid", resp_valid, 1);
      get_resp(0);

      // timeout after exactly 4 WAIT cycles, then backpressure
      issue(0, 3'b010, 32'h8000_0010, 0, 1, 0, 1);
      chk("to_mv", mem_valid, 1);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("to_wait_cycles", n, 4);
      get_resp(5);

      // reset in WAIT drops the transaction; late rvalid ignored
      issue(0, 3'b010, 32'h8000_0004, 0, 0, 0, 0);
      chk("rs_mv", mem_valid, 1);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rs_resp_valid", resp_valid, 0);
         chk("rs_req_ready", req_ready, 1);
         chk("rs_mem_valid", mem_valid, 0);
         @(negedge clk);
      end

      issue(0, 3'b010, 32'h8000_0004, 0, 1, 32'hDEAD_BEEF, 0);
      mem_txn(32'h8000_0004, 0, 4'b0000, 0, 1, 0, 32'hDEAD_BEEF);
      get_resp(0);

      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

endmodule
